multi_cycle_control: RTL and testbench

//  Main control FSM for the multi-cycle RISC-V core. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multi_cycle_pkg.sv | 53 +++++
 rtl/multi_cycle_control_opcode_class_decoder.sv | 25 ++
 rtl/multi_cycle_control.sv | 149 ++++++++++++++
 tb/tb_multi_cycle_control.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, FSM states,
// ALU_Op selectors (matching ALU_Control), mux selects and the instruction class bundle.
package multi_cycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_OP_R   = 3'b000;
  localparam logic [2:0] ALU_OP_I   = 3'b001;
  localparam logic [2:0] ALU_OP_U   = 3'b010;
  localparam logic [2:0] ALU_OP_ADD = 3'b011;
  localparam logic [2:0] ALU_OP_SUB = 3'b100;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

  localparam logic [1:0] WB_SRC_ALUOUT = 2'b00;
  localparam logic [1:0] WB_SRC_MDR    = 2'b01;
  localparam logic [1:0] WB_SRC_PC     = 2'b10;

  localparam logic [1:0] A_SRC_PC     = 2'b00;
  localparam logic [1:0] A_SRC_RS1    = 2'b01;
  localparam logic [1:0] A_SRC_OLD_PC = 2'b10;

  localparam logic [1:0] B_SRC_RS2   = 2'b00;
  localparam logic [1:0] B_SRC_FOUR  = 2'b01;
  localparam logic [1:0] B_SRC_IMM   = 2'b10;

  typedef struct packed {
    logic r;
    logic i_alu;
    logic lui;
    logic load;
    logic store;
    logic branch;
    logic jal;
  } instr_class_t;

endpackage

// File: rtl/multi_cycle_control_opcode_class_decoder.sv
// Combinational opcode classifier: one-hot instruction class plus a legal flag.
module opcode_class_decoder
  import multi_cycle_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls,
  output logic         legal
);

  always_comb begin
    cls   = '0;
    legal = 1'b1;
    case (opcode)
      OP_R:      cls.r      = 1'b1;
      OP_I_ALU:  cls.i_alu  = 1'b1;
      OP_LUI:    cls.lui    = 1'b1;
      OP_LOAD:   cls.load   = 1'b1;
      OP_STORE:  cls.store  = 1'b1;
      OP_BRANCH: cls.branch = 1'b1;
      OP_JAL:    cls.jal    = 1'b1;
      default:   legal      = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle core: sequences FETCH/DECODE/EXEC/MEM/WB and
// decodes datapath strobes and mux selects from the state register.
module multi_cycle_control
  import multi_cycle_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic [1:0] pc_source_o,
  output logic       ir_write_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] mem_to_reg_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       illegal_o,
  output logic [2:0] state_o
);

  state_t       state;
  instr_class_t cls;
  logic         legal;
  logic         unused_funct3;

  // Only the BEQ/BNE sense bit matters to the controller.
  assign unused_funct3 = ^funct3_i[2:1];

  opcode_class_decoder u_decoder (
    .opcode (opcode_i),
    .cls    (cls),
    .legal  (legal)
  );

  // State register and transitions; opcode_i comes straight from IR, which is stable after FETCH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready_i) state <= S_DECODE;
        S_DECODE: begin
          if (legal)                state <= S_EXEC;
          else if (TRAP_ON_ILLEGAL) state <= S_TRAP;
          else                      state <= S_FETCH;
        end
        S_EXEC: begin
          if (cls.load || cls.store)                      state <= S_MEM;
          else if (cls.r || cls.i_alu || cls.lui || cls.jal) state <= S_WB;
          else                                            state <= S_FETCH;
        end
        S_MEM: begin
          if (!(cls.load || cls.store)) state <= S_FETCH;
          else if (mem_ready_i)         state <= cls.load ? S_WB : S_FETCH;
          else                          state <= S_MEM;
        end
        S_WB:     state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_FETCH;
      endcase
    end
  end

  assign state_o = state;

  // Output decode from the state register; reset forces every strobe and select low.
  always_comb begin
    pc_write_o   = 1'b0;
    pc_source_o  = PC_SRC_ALU;
    ir_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    mem_to_reg_o = WB_SRC_ALUOUT;
    alu_src_a_o  = A_SRC_PC;
    alu_src_b_o  = B_SRC_RS2;
    alu_op_o     = ALU_OP_R;
    illegal_o    = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = B_SRC_FOUR;
          alu_op_o    = ALU_OP_ADD;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_a_o = A_SRC_OLD_PC;
          alu_src_b_o = B_SRC_IMM;
          alu_op_o    = ALU_OP_ADD;
        end
        S_EXEC: begin
          if (cls.r) begin
            alu_src_a_o = A_SRC_RS1;
          end else if (cls.i_alu) begin
            alu_src_a_o = A_SRC_RS1;
            alu_src_b_o = B_SRC_IMM;
            alu_op_o    = ALU_OP_I;
          end else if (cls.lui) begin
            alu_src_a_o = A_SRC_RS1;
            alu_src_b_o = B_SRC_IMM;
            alu_op_o    = ALU_OP_U;
          end else if (cls.load || cls.store) begin
            alu_src_a_o = A_SRC_RS1;
            alu_src_b_o = B_SRC_IMM;
            alu_op_o    = ALU_OP_ADD;
          end else if (cls.branch) begin
            // Target was computed into ALUOut during DECODE; the ALU compares here.
            alu_src_a_o = A_SRC_RS1;
            alu_op_o    = ALU_OP_SUB;
            pc_source_o = PC_SRC_ALUOUT;
            pc_write_o  = zero_i ^ funct3_i[0];
          end else if (cls.jal) begin
            pc_source_o = PC_SRC_ALUOUT;
            pc_write_o  = 1'b1;
          end else begin
            pc_write_o  = 1'b0;
          end
        end
        S_MEM: begin
          i_or_d_o    = cls.load || cls.store;
          mem_read_o  = cls.load;
          mem_write_o = cls.store;
        end
        S_WB: begin
          reg_write_o = 1'b1;
          if (cls.load)     mem_to_reg_o = WB_SRC_MDR;
          else if (cls.jal) mem_to_reg_o = WB_SRC_PC;
          else              mem_to_reg_o = WB_SRC_ALUOUT;
        end
        S_TRAP:  illegal_o = 1'b1;
        default: illegal_o = 1'b0;
      endcase
    end else begin
      illegal_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench: builds an expected per-cycle trace for each instruction from the
// instruction-level rules (class, stall counts, branch outcome) and compares every cycle.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode_i = 7'd0;
  logic [2:0] funct3_i = 3'd0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o, illegal_o;
  logic [1:0] pc_source_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o;
  logic [2:0] alu_op_o, state_o;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  multi_cycle_control dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .funct3_i(funct3_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .pc_source_o(pc_source_o),
    .ir_write_o(ir_write_o), .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  // One clock cycle: values to drive and outputs expected during that cycle.
  typedef struct packed {
    logic       rst;
    logic       ready;
    logic       zero;
    logic [2:0] state;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] op;
    logic       illegal;
  } cyc_t;

  cyc_t q[$];

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c = '0;
    c.rst   = 1'b1;
    c.state = st;
    c.ready = 1'($urandom_range(0, 1));
    c.zero  = 1'($urandom_range(0, 1));
    return c;
  endfunction

  function automatic logic [20:0] outs(input cyc_t c);
    return {c.state, c.pc_write, c.pc_source, c.ir_write, c.i_or_d, c.mem_read, c.mem_write,
            c.reg_write, c.mem_to_reg, c.a, c.b, c.op, c.illegal};
  endfunction

  task automatic push_fetch(input int nf);
    cyc_t c;
    for (int k = 0; k <= nf; k++) begin
      c = blank(3'd0);
      c.ready = (k == nf);
      c.mem_read = 1'b1; c.b = 2'b01; c.op = 3'b011;
      c.ir_write = c.ready; c.pc_write = c.ready;
      q.push_back(c);
    end
    c = blank(3'd1);
    c.a = 2'b10; c.b = 2'b10; c.op = 3'b011;
    q.push_back(c);
  endtask

  // Expected trace of one legal instruction; abort replaces EXEC with a reset cycle.
  task automatic build_instr(input logic [6:0] opc, input logic [2:0] f3, input int nf,
                             input int nm, input logic zero_v, input bit abort);
    cyc_t c;
    bit is_ld, is_st;
    push_fetch(nf);
    c = blank(3'd2);
    if (abort) begin
      c.rst = 1'b0;
      q.push_back(c);
      return;
    end
    is_ld = (opc == 7'b0000011);
    is_st = (opc == 7'b0100011);
    case (opc)
      7'b0110011: begin c.a = 2'b01; c.b = 2'b00; c.op = 3'b000; end
      7'b0010011: begin c.a = 2'b01; c.b = 2'b10; c.op = 3'b001; end
      7'b0110111: begin c.a = 2'b01; c.b = 2'b10; c.op = 3'b010; end
      7'b0000011, 7'b0100011: begin c.a = 2'b01; c.b = 2'b10; c.op = 3'b011; end
      7'b1100011: begin
        c.a = 2'b01; c.b = 2'b00; c.op = 3'b100; c.pc_source = 2'b01;
        c.zero = zero_v;
        c.pc_write = f3[0] ? !zero_v : zero_v;
      end
      default: begin c.pc_source = 2'b01; c.pc_write = 1'b1; end
    endcase
    q.push_back(c);
    if (is_ld || is_st) begin
      for (int k = 0; k <= nm; k++) begin
        c = blank(3'd3);
        c.ready = (k == nm);
        c.i_or_d = 1'b1; c.mem_read = is_ld; c.mem_write = is_st;
        q.push_back(c);
      end
    end
    if (opc != 7'b1100011 && !is_st) begin
      c = blank(3'd4);
      c.reg_write = 1'b1;
      c.mem_to_reg = is_ld ? 2'b01 : (opc == 7'b1101111) ? 2'b10 : 2'b00;
      q.push_back(c);
    end
  endtask

  // Plays the queued trace against the DUT, comparing outputs each cycle.
  task automatic run(input string name, input logic [6:0] opc, input logic [2:0] f3);
    logic [20:0] act, exp;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin opcode_i = opc; funct3_i = f3; end
      reset = q[i].rst; mem_ready_i = q[i].ready; zero_i = q[i].zero;
      #1;
      exp = outs(q[i]);
      act = {state_o, pc_write_o, pc_source_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
             reg_write_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o};
      total++;
      if (act !== exp) $display("FAIL %s cycle %0d: got %h expected %h", name, i, act, exp);
      else passed++;
    end
    q.delete();
  endtask

  task automatic test_reset();
    cyc_t c;
    reset = 1'b0; mem_ready_i = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      c = blank(3'd0);
      c.rst = 1'b0; c.ready = 1'b1;
      q.push_back(c);
    end
    run("reset", 7'b0110011, 3'd0);
  endtask

  task automatic test_rtype();
    build_instr(7'b0110011, 3'd0, 0, 0, 1'b0, 1'b0);
    run("rtype", 7'b0110011, 3'd0);
  endtask

  task automatic test_load_stall();
    build_instr(7'b0000011, 3'd2, 0, 2, 1'b0, 1'b0);
    run("load_stall", 7'b0000011, 3'd2);
  endtask

  task automatic test_branch();
    for (int k = 0; k < 4; k++) begin
      build_instr(7'b1100011, {2'b00, k[1]}, 0, 0, k[0], 1'b0);
      run("branch", 7'b1100011, {2'b00, k[1]});
    end
  endtask

  task automatic test_store();
    build_instr(7'b0100011, 3'd2, 0, 0, 1'b0, 1'b0);
    run("store", 7'b0100011, 3'd2);
  endtask

  task automatic test_jal();
    build_instr(7'b1101111, 3'd0, 0, 0, 1'b0, 1'b0);
    run("jal", 7'b1101111, 3'd0);
  endtask

  task automatic test_reset_mid_exec();
    build_instr(7'b0110011, 3'd0, 0, 0, 1'b0, 1'b1);
    run("reset_mid_exec", 7'b0110011, 3'd0);
    build_instr(7'b0110011, 3'd0, 0, 0, 1'b0, 1'b0);
    run("after_abort", 7'b0110011, 3'd0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [7];
    logic [6:0] opc;
    logic [2:0] f3;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
    for (int n = 0; n < 40; n++) begin
      opc = ops[$urandom_range(0, 6)];
      f3  = 3'($urandom_range(0, 7));
      build_instr(opc, f3, $urandom_range(0, 2), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'b0);
      run("back_to_back", opc, f3);
    end
  endtask

  task automatic test_trap();
    cyc_t c;
    push_fetch(1);
    for (int k = 0; k < 12; k++) begin
      c = blank(3'd5);
      c.illegal = 1'b1;
      q.push_back(c);
    end
    c = blank(3'd5);
    c.rst = 1'b0;
    q.push_back(c);
    run("trap", 7'b1111111, 3'd0);
    build_instr(7'b0110011, 3'd0, 0, 0, 1'b0, 1'b0);
    run("after_trap", 7'b0110011, 3'd0);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_stall();
    test_branch();
    test_store();
    test_jal();
    test_reset_mid_exec();
    test_back_to_back();
    test_trap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
